// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: multi-port CDB wakeup, oldest-first
// issue relative to the ROB head, selective squash and dispatch bypass.
package rs_pkg;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL,
      OP_LSR, OP_MOV, OP_LDUR, OP_STUR, OP_CMP, OP_B
   } fu_op_t;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;
   typedef logic [3:0] cond_t;
endpackage

module rs_age_ordered
   import rs_pkg::*;
#(
   parameter int RS_SIZE      = 8,
   parameter int NUM_CDB      = 2,
   parameter int GPR_SIZE     = 64,
   parameter int ROB_IDX_SIZE = 5
)(
   input  logic                                   in_clk,
   input  logic                                   in_rst,
   input  logic                                   in_disp_valid,
   output logic                                   out_disp_ready,
   input  fu_op_t                                 in_disp_op,
   input  logic [ROB_IDX_SIZE-1:0]                in_disp_dst,
   input  logic                                   in_disp_op1_valid,
   input  logic [GPR_SIZE-1:0]                    in_disp_op1_value,
   input  logic [ROB_IDX_SIZE-1:0]                in_disp_op1_tag,
   input  logic                                   in_disp_op2_valid,
   input  logic [GPR_SIZE-1:0]                    in_disp_op2_value,
   input  logic [ROB_IDX_SIZE-1:0]                in_disp_op2_tag,
   input  logic                                   in_disp_op1_add,
   input  logic                                   in_disp_uses_nzcv,
   input  logic                                   in_disp_nzcv_valid,
   input  nzcv_t                                  in_disp_nzcv,
   input  logic [ROB_IDX_SIZE-1:0]                in_disp_nzcv_tag,
   input  logic                                   in_disp_set_nzcv,
   input  cond_t                                  in_disp_cond,
   input  logic [NUM_CDB-1:0]                     in_cdb_valid,
   input  logic [NUM_CDB-1:0][ROB_IDX_SIZE-1:0]   in_cdb_tag,
   input  logic [NUM_CDB-1:0][GPR_SIZE-1:0]       in_cdb_value,
   input  logic [NUM_CDB-1:0]                     in_cdb_set_nzcv,
   input  nzcv_t [NUM_CDB-1:0]                    in_cdb_nzcv,
   input  logic [ROB_IDX_SIZE-1:0]                in_rob_head,
   input  logic                                   in_flush,
   input  logic [ROB_IDX_SIZE-1:0]                in_flush_tag,
   input  logic                                   in_fu_ready,
   output logic                                   out_issue_valid,
   output fu_op_t                                 out_issue_op,
   output logic [GPR_SIZE-1:0]                    out_issue_val_a,
   output logic [GPR_SIZE-1:0]                    out_issue_val_b,
   output logic [ROB_IDX_SIZE-1:0]                out_issue_dst,
   output logic                                   out_issue_set_nzcv,
   output nzcv_t                                  out_issue_nzcv,
   output cond_t                                  out_issue_cond,
   output logic                                   out_full,
   output logic [$clog2(RS_SIZE+1)-1:0]           out_count
);
   localparam int CW = $clog2(RS_SIZE+1);
   localparam int IW = $clog2(RS_SIZE);
   localparam int R  = ROB_IDX_SIZE;
   localparam int G  = GPR_SIZE;

   typedef struct packed {
      logic          valid;
      fu_op_t        op;
      logic [R-1:0]  dst;
      logic          op1_v;
      logic [G-1:0]  op1_val;
      logic [R-1:0]  op1_tag;
      logic          op2_v;
      logic [G-1:0]  op2_val;
      logic [R-1:0]  op2_tag;
      logic          op1_add;
      logic          uses_nzcv;
      logic          nzcv_v;
      nzcv_t         nzcv;
      logic [R-1:0]  nzcv_tag;
      logic          set_nzcv;
      cond_t         cond;
   } ent_t;

   ent_t               ents [RS_SIZE];
   ent_t               nxt  [RS_SIZE];
   ent_t               disp_e;
   ent_t               disp_w;
   logic [RS_SIZE-1:0] rdy;
   logic [RS_SIZE-1:0] kill;
   logic               kill_d;
   logic               found;
   logic               free_found;
   logic               disp_acc;
   logic               issue_fire;
   logic [IW-1:0]      sel;
   logic [IW-1:0]      free_idx;
   logic [R-1:0]       best_age;
   logic [CW-1:0]      cnt;

   function automatic logic [R-1:0] age(input logic [R-1:0] t,
                                        input logic [R-1:0] h);
      return t - h;
   endfunction

   // Iterating from the highest port down lets the lowest matching port win.
   function automatic ent_t wake(input ent_t e);
      ent_t w;
      w = e;
      for (int p = NUM_CDB-1; p >= 0; p--) begin
         if (in_cdb_valid[p]) begin
            if (!e.op1_v && e.op1_tag == in_cdb_tag[p]) begin
               w.op1_v   = 1'b1;
               w.op1_val = e.op1_add ? e.op1_val + in_cdb_value[p]
                                     : in_cdb_value[p];
            end
            if (!e.op2_v && e.op2_tag == in_cdb_tag[p]) begin
               w.op2_v   = 1'b1;
               w.op2_val = in_cdb_value[p];
            end
            if (e.uses_nzcv && !e.nzcv_v && in_cdb_set_nzcv[p] &&
                e.nzcv_tag == in_cdb_tag[p]) begin
               w.nzcv_v = 1'b1;
               w.nzcv   = in_cdb_nzcv[p];
            end
         end
      end
      return w;
   endfunction

   always_comb begin
      disp_e           = '0;
      disp_e.valid     = 1'b1;
      disp_e.op        = in_disp_op;
      disp_e.dst       = in_disp_dst;
      disp_e.op1_v     = in_disp_op1_valid;
      disp_e.op1_val   = in_disp_op1_value;
      disp_e.op1_tag   = in_disp_op1_tag;
      disp_e.op2_v     = in_disp_op2_valid;
      disp_e.op2_val   = in_disp_op2_value;
      disp_e.op2_tag   = in_disp_op2_tag;
      disp_e.op1_add   = in_disp_op1_add;
      disp_e.uses_nzcv = in_disp_uses_nzcv;
      disp_e.nzcv_v    = in_disp_nzcv_valid;
      disp_e.nzcv      = in_disp_nzcv;
      disp_e.nzcv_tag  = in_disp_nzcv_tag;
      disp_e.set_nzcv  = in_disp_set_nzcv;
      disp_e.cond      = in_disp_cond;
      disp_w           = wake(disp_e);
   end

   always_comb begin
      found      = 1'b0;
      sel        = '0;
      best_age   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      cnt        = '0;
      kill_d     = age(in_disp_dst, in_rob_head) >
                   age(in_flush_tag, in_rob_head);
      for (int i = 0; i < RS_SIZE; i++) begin
         rdy[i]  = ents[i].valid & ents[i].op1_v & ents[i].op2_v &
                   (~ents[i].uses_nzcv | ents[i].nzcv_v);
         kill[i] = age(ents[i].dst, in_rob_head) >
                   age(in_flush_tag, in_rob_head);
         cnt     = cnt + CW'(ents[i].valid);
         if (rdy[i] && (!found ||
             age(ents[i].dst, in_rob_head) < best_age)) begin
            found    = 1'b1;
            sel      = IW'(i);
            best_age = age(ents[i].dst, in_rob_head);
         end
         if (!ents[i].valid && !free_found) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   assign out_full        = (cnt == CW'(RS_SIZE));
   assign out_count       = cnt;
   assign out_disp_ready  = ~out_full;
   assign disp_acc        = in_disp_valid & out_disp_ready & free_found;
   assign out_issue_valid = found & ~in_flush;
   assign issue_fire      = out_issue_valid & in_fu_ready;

   assign out_issue_op       = ents[sel].op;
   assign out_issue_val_a    = ents[sel].op1_val;
   assign out_issue_val_b    = ents[sel].op2_val;
   assign out_issue_dst      = ents[sel].dst;
   assign out_issue_set_nzcv = ents[sel].set_nzcv;
   assign out_issue_nzcv     = ents[sel].nzcv;
   assign out_issue_cond     = ents[sel].cond;

   // Removal and dispatch touch disjoint slots, so all updates coexist.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         nxt[i] = ents[i].valid ? wake(ents[i]) : ents[i];
         if (in_flush && kill[i])
            nxt[i].valid = 1'b0;
         else if (issue_fire && sel == IW'(i))
            nxt[i].valid = 1'b0;
         if (disp_acc && !(in_flush && kill_d) && free_idx == IW'(i))
            nxt[i] = disp_w;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         for (int i = 0; i < RS_SIZE; i++)
            ents[i] <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++)
            ents[i] <= nxt[i];
      end
   end
endmodule
